// File: rtl/bp_fe_pkg.sv
// Shared types and helpers for the frontend request arbiter.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_send   = 2'd1,
    e_meta   = 2'd2,
    e_locked = 2'd3
  } bp_fe_req_arb_state_e;

  // Counter width able to hold the value `limit` itself.
  function automatic int unsigned bp_fe_ctr_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bp_fe_req_arb_starve_ctr.sv
// Saturating up-counter with clear; counts demand grants made while a prefetch waits.
module bp_fe_req_arb_starve_ctr
  import bp_fe_pkg::*;
#(
  parameter int starve_limit_p = 8,
  localparam int width_lp = bp_fe_ctr_width(starve_limit_p)
)(
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam logic [width_lp-1:0] limit_lp = width_lp'(starve_limit_p);

  logic [width_lp-1:0] count_q;

  assign sat_o = (count_q == limit_lp);

  // Clear dominates so a prefetch grant always restarts the count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && !sat_o) begin
      count_q <= count_q + width_lp'(1);
    end
  end

endmodule

// File: rtl/bp_fe_req_arbiter.sv
// Arbitrates demand and next-line prefetch requests onto one cache request port.
// Prefetch arbitration is built only when BP_FE_REQ_ARB_PREFETCH_EN is defined.
module bp_fe_req_arbiter
  import bp_fe_pkg::*;
#(
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8,
  parameter int starve_limit_p   = 8
)(
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [req_width_p-1:0]      dmd_req_i,
  input  logic [metadata_width_p-1:0] dmd_meta_i,
  input  logic                        dmd_v_i,
  output logic                        dmd_yumi_o,

  input  logic [req_width_p-1:0]      pf_req_i,
  input  logic [metadata_width_p-1:0] pf_meta_i,
  input  logic                        pf_v_i,
  output logic                        pf_yumi_o,

  input  logic                        pf_flush_i,

  output logic [req_width_p-1:0]      cache_req_o,
  output logic                        cache_req_v_o,
  input  logic                        cache_req_yumi_i,

  output logic [metadata_width_p-1:0] cache_req_metadata_o,
  output logic                        cache_req_metadata_v_o,

  input  logic                        cache_req_lock_i,
  input  logic                        cache_req_credits_full_i,
  input  logic                        cache_req_credits_empty_i,

  output logic                        grant_src_o
);

  bp_fe_req_arb_state_e        state_q;
  logic [req_width_p-1:0]      req_q;
  logic [metadata_width_p-1:0] meta_q;
  logic                        src_q;

  logic grant_ok;
  logic dmd_elig;
  logic dmd_grant;
  logic pf_grant;

  // Yumi is combinational, so it must be masked while reset is held.
  assign grant_ok = (state_q == e_idle) && !reset_i && !cache_req_credits_full_i;
  assign dmd_elig = grant_ok && dmd_v_i;

`ifdef BP_FE_REQ_ARB_PREFETCH_EN
  logic pf_elig;
  logic starved;

  assign pf_elig   = grant_ok && pf_v_i && cache_req_credits_empty_i;
  assign pf_grant  = pf_elig && (starved || !dmd_elig);
  assign dmd_grant = dmd_elig && !pf_grant;

  bp_fe_req_arb_starve_ctr #(
    .starve_limit_p(starve_limit_p)
  ) starve_ctr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (pf_grant || !pf_v_i),
    .inc_i  (dmd_grant),
    .sat_o  (starved)
  );
`else
  logic unused_pf;

  assign unused_pf = pf_v_i ^ cache_req_credits_empty_i;
  assign pf_grant  = 1'b0;
  assign dmd_grant = dmd_elig;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      req_q   <= '0;
      meta_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      case (state_q)
        e_idle: begin
          if (dmd_grant || pf_grant) begin
            state_q <= e_send;
            req_q   <= pf_grant ? pf_req_i  : dmd_req_i;
            meta_q  <= pf_grant ? pf_meta_i : dmd_meta_i;
            src_q   <= pf_grant;
          end
        end
        e_send: begin
          // Acceptance wins over a same-cycle flush; flush only cancels prefetches.
          if (cache_req_yumi_i) begin
            state_q <= e_meta;
          end else if (pf_flush_i && src_q) begin
            state_q <= e_idle;
          end
        end
        e_meta: begin
          state_q <= cache_req_lock_i ? e_locked : e_idle;
        end
        e_locked: begin
          if (!cache_req_lock_i) begin
            state_q <= e_idle;
          end
        end
        default: begin
          state_q <= e_idle;
        end
      endcase
    end
  end

  assign dmd_yumi_o             = dmd_grant;
  assign pf_yumi_o              = pf_grant;
  assign cache_req_o            = req_q;
  assign cache_req_v_o          = (state_q == e_send);
  assign cache_req_metadata_o   = meta_q;
  assign cache_req_metadata_v_o = (state_q == e_meta);
  assign grant_src_o            = src_q;

endmodule

// File: doc/bp_fe_req_arbiter.md
BP_FE_REQ_ARBITER -- requirements
Module: bp_fe_req_arbiter

Interface
REQ-001 SHALL have parameter req_width_p, default 64, meaning width of one cache request packet.
REQ-002 SHALL have parameter metadata_width_p, default 8, meaning width of the request metadata packet.
REQ-003 SHALL have parameter starve_limit_p, default 8, meaning consecutive demand grants tolerated while a prefetch waits.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port reset_i, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have ports dmd_req_i (in, req_width_p), dmd_meta_i (in, metadata_width_p), dmd_v_i (in, 1) and dmd_yumi_o (out, 1): the demand (icache miss) requester.
REQ-007 SHALL have ports pf_req_i (in, req_width_p), pf_meta_i (in, metadata_width_p), pf_v_i (in, 1) and pf_yumi_o (out, 1): the next-line prefetch requester.
REQ-008 SHALL have port pf_flush_i, input, 1, which cancels a held, not-yet-accepted prefetch.
REQ-009 SHALL have ports cache_req_o (out, req_width_p), cache_req_v_o (out, 1) and cache_req_yumi_i (in, 1): the downstream request.
REQ-010 SHALL have ports cache_req_metadata_o (out, metadata_width_p) and cache_req_metadata_v_o (out, 1): the downstream metadata.
REQ-011 SHALL have ports cache_req_lock_i, cache_req_credits_full_i and cache_req_credits_empty_i, each input, 1, from the engine.
REQ-012 SHALL have port grant_src_o, output, 1, indicating the source of the held request: 0 = demand, 1 = prefetch.

Function
REQ-013 SHALL implement FSM states e_idle, e_send, e_meta, e_locked.
REQ-014 In e_idle, with credits_full low and at least one requester valid, SHALL select a winner, raise its yumi for one cycle, latch its request, metadata and source, and enter e_send next cycle.
REQ-015 Winner selection SHALL be demand first, except prefetch wins when the starve counter equals starve_limit_p.
REQ-016 Prefetch SHALL be eligible only while cache_req_credits_empty_i is high; demand needs only credits_full low.
REQ-017 In e_idle with credits_full high, SHALL assert no yumi and stay in e_idle.
REQ-018 In e_send, SHALL assert cache_req_v_o with the latched request, holding it stable until cache_req_yumi_i.
REQ-019 On cache_req_yumi_i in e_send, SHALL enter e_meta.
REQ-020 Request latency SHALL be exactly one cycle from yumi to the requester until cache_req_v_o rises.
REQ-021 In e_meta, SHALL assert cache_req_metadata_v_o for exactly one cycle with the latched metadata.
REQ-022 Leaving e_meta, SHALL go to e_locked if cache_req_lock_i is high, else to e_idle.
REQ-023 In e_locked, SHALL grant nothing and return to e_idle the cycle after lock falls.
REQ-024 pf_flush_i in e_send with prefetch latched and yumi low SHALL drop the request and go to e_idle; flush SHALL never drop a demand request.
REQ-025 Simultaneous pf_flush_i and cache_req_yumi_i SHALL honor the yumi.
REQ-026 The starve counter SHALL increment on each demand grant while pf_v_i is high, saturate at starve_limit_p, and clear on a prefetch grant or when pf_v_i is low.
REQ-027 dmd_yumi_o and pf_yumi_o SHALL never be high in the same cycle.
REQ-028 cache_req_v_o and cache_req_metadata_v_o SHALL never be high in the same cycle.

Reset
REQ-029 Reset SHALL force state e_idle and a starve counter of 0.
REQ-030 Reset SHALL hold all valid/yumi outputs low and zero grant_src_o, cache_req_o and cache_req_metadata_o.
REQ-031 Reset asserted mid-transaction SHALL discard the held request, with no metadata emitted after release.

Configuration
REQ-032 With macro BP_FE_REQ_ARB_PREFETCH_EN defined, SHALL behave as above.
REQ-033 Without BP_FE_REQ_ARB_PREFETCH_EN, pf_yumi_o SHALL be tied 0, the starve counter is absent, and demand is granted whenever eligible.

Structure
REQ-034 bp_fe_req_arb_state_e SHALL reside in bp_fe_pkg.
REQ-035 The starve counter SHALL be one sub-module, bp_fe_req_arb_starve_ctr (saturating up-counter with clear).

Verification
REQ-036 Scenario: dmd_v_i=1 only, yumi after 2 cycles -> dmd_yumi_o at cycle 0, cache_req_v_o cycles 1-3, metadata_v at cycle 4, back to e_idle at 5.
REQ-037 Scenario: both valid continuously, starve_limit_p=8 -> 8 demand grants, then 1 prefetch grant, then the counter restarts at 0.
REQ-038 Scenario: credits_full=1 for 5 cycles with dmd_v_i=1 -> no yumi; grant on the first cycle after it falls.
REQ-039 Scenario: prefetch held in e_send, pf_flush_i=1, yumi=0 -> cache_req_v_o low next cycle, no metadata_v, e_idle.
REQ-040 Scenario: lock_i=1 for 3 cycles after e_meta -> no grants during lock, demand grant 1 cycle after lock falls.
REQ-041 Scenario: reset pulsed in e_send, then the macro undefined with pf_v_i=1 -> outputs zeroed, pf_yumi_o never asserted.
